// File: rtl/sin_pkg.sv
// rtl/sin_pkg.sv - shared constants and state type for the sin range-reduction path
package sin_pkg;

    // Q3.12 angle constants
    localparam logic signed [15:0] TWO_PI  = 16'sh6488;
    localparam logic signed [15:0] PI      = 16'sh3244;
    localparam logic signed [15:0] HALF_PI = 16'sh1922;
    localparam logic signed [15:0] NEG_PI      = -PI;
    localparam logic signed [15:0] NEG_HALF_PI = -HALF_PI;

    // 17-bit sign-extended forms so add/sub cannot wrap before truncation
    localparam logic signed [16:0] TWO_PI_W = {TWO_PI[15], TWO_PI};
    localparam logic signed [16:0] PI_W     = {PI[15], PI};
    localparam logic signed [16:0] NEG_PI_W = {NEG_PI[15], NEG_PI};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        FOLD   = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/sin_range_reduce.sv
// rtl/sin_range_reduce.sv - reduces a Q3.12 angle into [-pi/2, pi/2] preserving sin()
module sin_range_reduce
    import sin_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] angle,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] x_out,
    output logic        out_valid,
    input  logic        out_ready
);

    state_t             state;
    state_t             state_next;
    logic signed [15:0] x;
    logic signed [16:0] x_w;

    assign x_w = {x[15], x};

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic: REDUCE repeats until x lies in [-pi, pi]
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = REDUCE;
            REDUCE:  if (!((x > PI) || (x < NEG_PI))) state_next = FOLD;
            FOLD:    state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // handshake outputs depend on state only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // working register: load, wrap by 2*pi, then reflect about +/-pi/2
    always_ff @(posedge clk) begin
        if (rst) begin
            x <= 16'sh0000;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) x <= angle;
                end
                REDUCE: begin
                    if (x > PI) begin
                        x <= 16'(x_w - TWO_PI_W);
                    end else if (x < NEG_PI) begin
                        x <= 16'(x_w + TWO_PI_W);
                    end
                end
                FOLD: begin
                    if (x > HALF_PI) begin
                        x <= 16'(PI_W - x_w);
                    end else if (x < NEG_HALF_PI) begin
                        x <= 16'(NEG_PI_W - x_w);
                    end
                end
                default: ;
            endcase
        end
    end

    // x is a flop and is only modified before DONE, so it is stable while out_valid
    assign x_out = x;

endmodule

// File: tb/tb_sin_range_reduce.sv
// tb/tb_sin_range_reduce.sv - self-checking bench for sin_range_reduce
module tb_sin_range_reduce;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] angle;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x_out;
    logic        out_valid;
    logic        out_ready;

    int n_cmp = 0;
    int n_err = 0;

    sin_range_reduce dut (
        .clk       (clk),
        .rst       (rst),
        .angle     (angle),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_out     (x_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // reference: integer radians*4096, wrap into [-pi, pi], reflect into [-pi/2, pi/2]
    task automatic model(input logic [15:0] a, output logic [15:0] r, output int steps);
        int v;
        v = int'($signed(a));
        steps = 0;
        while (v > 12868)  begin v = v - 25736; steps++; end
        while (v < -12868) begin v = v + 25736; steps++; end
        if (v > 6434)       v = 12868 - v;
        else if (v < -6434) v = -12868 - v;
        r = 16'(v);
    endtask

    // one full transfer; caller is 1 time unit after a rising edge with the DUT idle
    task automatic transact(input logic [15:0] a, input int hold,
                            input bit poke_hold, input bit poke_release);
        logic [15:0] er;
        int          es;
        int          lat;
        model(a, er, es);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        angle     = a;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        angle    = 16'($urandom);
        lat      = 1;
        while (!out_valid && lat < 20) begin
            check("in_ready_busy", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 3 + es);
        check("x_out", {16'd0, x_out}, {16'd0, er});
        for (int i = 0; i < hold; i++) begin
            in_valid = poke_hold;
            angle    = 16'($urandom);
            @(posedge clk); #1;
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_x", {16'd0, x_out}, {16'd0, er});
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = poke_release;
        angle     = 16'($urandom);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("post_valid", {31'd0, out_valid}, 32'd0);
        check("post_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        angle     = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_x_out", {16'd0, x_out}, 32'd0);

        transact(16'h1000, 0, 1'b0, 1'b0);
        transact(16'h2000, 0, 1'b0, 1'b0);
        transact(16'h7000, 0, 1'b0, 1'b0);
        transact(16'h8000, 0, 1'b0, 1'b0);
        transact(16'h3244, 5, 1'b1, 1'b1);
        transact(16'hCDBC, 1, 1'b0, 1'b1);
        transact(16'h1922, 0, 1'b0, 1'b0);
        transact(16'hE6DE, 2, 1'b1, 1'b0);
        transact(16'h7FFF, 0, 1'b0, 1'b0);

        // reset while in REDUCE aborts without an output transfer
        angle    = 16'h7000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_x_out", {16'd0, x_out}, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_quiet", {31'd0, out_valid}, 32'd0);
        end

        for (int n = 0; n < 40; n++) begin
            transact(16'($urandom), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
